// File: rtl/hack_vga_pkg.sv
// Shared VGA raster constants and Hack screen geometry for the video blocks.
package hack_vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_TOTAL  = 525;

  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/vga_timing.sv
// 640x480@60 raster counters with combinational sync/blank decode; consumers
// register the decoded signals alongside their own pixel pipeline.
module vga_timing
  import hack_vga_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [9:0] o_hcount,
  output logic [9:0] o_vcount,
  output logic       o_hsync,
  output logic       o_vsync,
  output logic       o_blank,
  output logic       o_vblank,
  output logic       o_frame_end
);

  logic [9:0] hcount_reg, hcount_next;
  logic [9:0] vcount_reg, vcount_next;
  logic       line_end;

  assign line_end    = (hcount_reg == 10'(H_TOTAL - 1));
  assign o_frame_end = line_end && (vcount_reg == 10'(V_TOTAL - 1));

  always_comb begin
    hcount_next = hcount_reg + 10'd1;
    vcount_next = vcount_reg;
    if (line_end) begin
      hcount_next = '0;
      vcount_next = o_frame_end ? '0 : vcount_reg + 10'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      hcount_reg <= '0;
      vcount_reg <= '0;
    end else begin
      hcount_reg <= hcount_next;
      vcount_reg <= vcount_next;
    end
  end

  assign o_hcount = hcount_reg;
  assign o_vcount = vcount_reg;
  assign o_hsync  = !((hcount_reg >= 10'(H_ACTIVE + H_FP)) &&
                      (hcount_reg <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign o_vsync  = !((vcount_reg >= 10'(V_ACTIVE + V_FP)) &&
                      (vcount_reg <  10'(V_ACTIVE + V_FP + V_SYNC)));
  assign o_vblank = (vcount_reg >= 10'(V_ACTIVE));
  assign o_blank  = o_vblank || (hcount_reg >= 10'(H_ACTIVE));

endmodule

// File: rtl/hack_vga_reader.sv
// Hack screen scan-out: fetches 16-pixel words from RAM port 2 three cycles ahead
// of their first pixel and serialises them LSB-first inside a centred window.
module hack_vga_reader
  import hack_vga_pkg::*;
#(
  parameter logic [14:0] SCREEN_BASE = 15'h4000,
  parameter int          X0          = 64,
  parameter int          Y0          = 112,
  parameter rgb444_t     FG          = 12'h000,
  parameter rgb444_t     BG          = 12'hFFF,
  parameter rgb444_t     BORDER      = 12'h222
)
(
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [14:0] o_addr,
  input  logic [15:0] i_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_vblank
);

  logic [9:0] hcount, vcount;
  logic       hsync_raw, vsync_raw, blank, vblank_raw, frame_end;

  vga_timing u_timing (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .o_hcount    (hcount),
    .o_vcount    (vcount),
    .o_hsync     (hsync_raw),
    .o_vsync     (vsync_raw),
    .o_blank     (blank),
    .o_vblank    (vblank_raw),
    .o_frame_end (frame_end)
  );

  // Fetch phase counts from the first address cycle (X0-3) of the line.
  logic [9:0] fetch_ofs;
  logic [3:0] phase;
  logic [4:0] word_idx;
  logic [7:0] row;
  logic       win_line, win_col, fetch_span;
  logic       fetch_slot, capture_slot, load_slot;

  assign fetch_ofs  = hcount - 10'(X0 - 3);
  assign phase      = 4'(fetch_ofs);
  assign word_idx   = 5'(fetch_ofs >> 4);
  assign row        = 8'(vcount - 10'(Y0));
  assign win_line   = (vcount >= 10'(Y0)) && (vcount < 10'(Y0 + SCREEN_H));
  assign win_col    = (hcount >= 10'(X0)) && (hcount < 10'(X0 + SCREEN_W));
  assign fetch_span = win_line && (hcount >= 10'(X0 - 3)) &&
                      (hcount < 10'(X0 - 3 + SCREEN_W));

  assign fetch_slot   = fetch_span && (phase == 4'd0);
  assign capture_slot = fetch_span && (phase == 4'd1);
  assign load_slot    = fetch_span && (phase == 4'd2);

  logic [14:0] addr_reg, addr_next;
  logic [15:0] next_word_reg, next_word_next;
  logic [15:0] shift_reg, shift_next;
  rgb444_t     colour_reg, colour_next;
  logic        hsync_reg, vsync_reg, vblank_reg;

  always_comb begin
    addr_next = addr_reg;
    if (frame_end)
      addr_next = SCREEN_BASE;
    else if (fetch_slot)
      addr_next = SCREEN_BASE + {2'b00, row, word_idx};

    next_word_next = capture_slot ? i_data : next_word_reg;
    shift_next     = load_slot ? next_word_reg : {1'b0, shift_reg[15:1]};

    if (blank)
      colour_next = '0;
    else if (win_line && win_col)
      colour_next = shift_reg[0] ? FG : BG;
    else
      colour_next = BORDER;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_reg      <= SCREEN_BASE;
      next_word_reg <= '0;
      shift_reg     <= '0;
      colour_reg    <= '0;
      hsync_reg     <= 1'b1;
      vsync_reg     <= 1'b1;
      vblank_reg    <= 1'b0;
    end else begin
      addr_reg      <= addr_next;
      next_word_reg <= next_word_next;
      shift_reg     <= shift_next;
      colour_reg    <= colour_next;
      hsync_reg     <= hsync_raw;
      vsync_reg     <= vsync_raw;
      vblank_reg    <= vblank_raw;
    end
  end

  assign o_addr   = addr_reg;
  assign o_hsync  = hsync_reg;
  assign o_vsync  = vsync_reg;
  assign o_vblank = vblank_reg;
  assign o_r      = colour_reg.r;
  assign o_g      = colour_reg.g;
  assign o_b      = colour_reg.b;

endmodule
